ifu_ctrl: RTL and testbench

IFU_CTRL -- requirements
Module: ifu_ctrl

---
 rtl/ifu_pkg.sv | 26 ++
 rtl/ifu_ibuf.sv | 54 +++++
 rtl/ifu_ctrl.sv | 159 +++++++++++++++
 tb/tb_ifu_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and defaults for the instruction fetch unit.
//   ifu_state_t   - fetch FSM states
//   RST_PC_DEF    - default first fetch address after reset
//   ibuf_entry_t  - instruction buffer entry {pc, ir}; fields are sized for
//                   the widest supported AW/DW (32), narrower values are
//                   zero-extended on the way in.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    STALL = 2'd3
  } ifu_state_t;

  localparam int unsigned RST_PC_DEF = 32'h0;

  localparam int ENTRY_PC_W = 32;
  localparam int ENTRY_IR_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [ENTRY_IR_W-1:0] ir;
  } ibuf_entry_t;

endpackage

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: 2-entry instruction buffer (FIFO) between memory and EXU.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write one entry (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   flush      : empty the buffer; wins over push/pop
//   head       : current head entry
//   count      : number of valid entries (0..2)
module ifu_ibuf
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  ibuf_entry_t din,
  output ibuf_entry_t head,
  output logic [1:0]  count
);

  ibuf_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ifu_ctrl.sv
// ifu_ctrl: instruction fetch controller. Issues one fetch at a time to
// memory, buffers responses in ifu_ibuf and hands them to the EXU, and
// redirects fetch on a taken EXU transfer.
//   clk, rst_n          : clock, async active-low reset
//   ifu2mem_req_*       : fetch request (vld/rdy/addr)
//   mem2ifu_rsp_*       : fetch response (vld/data), always accepted
//   ifu2exu_req_*       : instruction to EXU (vld/rdy/ir/pc)
//   exu2ifu_taken/offset: redirect, sampled only on an EXU transfer
// AW and DW must not exceed 32.
//
// state | meaning
// IDLE  | reset state, moves to REQ on the first edge
// REQ   | request valid, waiting for memory to accept it
// WAIT  | one request outstanding, waiting for its response
// STALL | buffer full, waiting for the EXU to free a slot
module ifu_ctrl
  import ifu_pkg::*;
#(
  parameter int          AW     = 32,
  parameter int          DW     = 32,
  parameter int unsigned RST_PC = RST_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          ifu2mem_req_vld,
  input  logic          ifu2mem_req_rdy,
  output logic [AW-1:0] ifu2mem_req_addr,
  input  logic          mem2ifu_rsp_vld,
  input  logic [DW-1:0] mem2ifu_rsp_data,
  output logic          ifu2exu_req_vld,
  input  logic          ifu2exu_req_rdy,
  output logic [DW-1:0] ifu2exu_req_ir,
  output logic [AW-1:0] ifu2exu_req_pc,
  input  logic          exu2ifu_taken,
  input  logic [DW-1:0] exu2ifu_offset
);

  ifu_state_t  state;
  ifu_state_t  state_nxt;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic [AW-1:0] redir_tgt;
  logic [AW-1:0] pend_tgt;
  logic          pend;
  logic          outstanding;
  logic          discard;
  logic          mem_xfer;
  logic          exu_xfer;
  logic          redirect;
  logic          hold;
  logic          rsp_take;
  logic          push;
  logic [1:0]    buf_count;
  logic [1:0]    cnt_nxt;
  logic          credit_nxt;
  ibuf_entry_t   push_entry;
  ibuf_entry_t   head;

  assign mem_xfer  = ifu2mem_req_vld && ifu2mem_req_rdy;
  assign exu_xfer  = ifu2exu_req_vld && ifu2exu_req_rdy;
  assign redirect  = exu_xfer && exu2ifu_taken;
  assign hold      = ifu2mem_req_vld && !ifu2mem_req_rdy;
  assign redir_tgt = ifu2exu_req_pc + AW'(exu2ifu_offset);
  assign rsp_take  = mem2ifu_rsp_vld && outstanding;
  // A response landing in the redirect cycle belongs to the old stream.
  assign push      = rsp_take && !discard && !redirect;

  // Credit is judged on next-cycle occupancy with nothing outstanding,
  // which is the situation every transition into REQ leads to.
  assign cnt_nxt    = redirect ? 2'd0
                               : buf_count + {1'b0, push} - {1'b0, exu_xfer};
  assign credit_nxt = (cnt_nxt < 2'd2);

  always_comb begin
    push_entry    = '0;
    push_entry.pc = ENTRY_PC_W'(req_pc);
    push_entry.ir = ENTRY_IR_W'(mem2ifu_rsp_data);
  end

  ifu_ibuf u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (exu_xfer),
    .flush (redirect),
    .din   (push_entry),
    .head  (head),
    .count (buf_count)
  );

  assign ifu2exu_req_vld  = (buf_count != 2'd0);
  assign ifu2exu_req_pc   = head.pc[AW-1:0];
  assign ifu2exu_req_ir   = head.ir[DW-1:0];
  assign ifu2mem_req_addr = (state == IDLE) ? '0 : fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ifu2mem_req_vld = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        ifu2mem_req_vld = 1'b1;
        if (mem_xfer) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem2ifu_rsp_vld) state_nxt = credit_nxt ? REQ : STALL;
      end
      STALL: begin
        if (credit_nxt) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A redirect that arrives while a request is held cannot move the
  // address; it is parked in pend_tgt and applied once that request is
  // accepted, and the accepted request is then discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= AW'(RST_PC);
      req_pc      <= '0;
      pend        <= 1'b0;
      pend_tgt    <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (redirect && hold) begin
        pend     <= 1'b1;
        pend_tgt <= redir_tgt;
      end else if (redirect) begin
        fetch_pc <= redir_tgt;
        pend     <= 1'b0;
      end else if (mem_xfer) begin
        fetch_pc <= pend ? pend_tgt : fetch_pc + AW'(4);
        pend     <= 1'b0;
      end

      if (mem_xfer) begin
        req_pc      <= fetch_pc;
        outstanding <= 1'b1;
        discard     <= redirect || pend;
      end else if (rsp_take) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (redirect && outstanding) begin
        discard <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_ctrl.sv
module tb_ifu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu2mem_req_vld;
  logic        ifu2mem_req_rdy = 1'b0;
  logic [31:0] ifu2mem_req_addr;
  logic        mem2ifu_rsp_vld = 1'b0;
  logic [31:0] mem2ifu_rsp_data = '0;
  logic        ifu2exu_req_vld;
  logic        ifu2exu_req_rdy = 1'b0;
  logic [31:0] ifu2exu_req_ir;
  logic [31:0] ifu2exu_req_pc;
  logic        exu2ifu_taken = 1'b0;
  logic [31:0] exu2ifu_offset = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_ctrl #(.AW(32), .DW(32), .RST_PC(0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu2mem_req_vld  (ifu2mem_req_vld),
    .ifu2mem_req_rdy  (ifu2mem_req_rdy),
    .ifu2mem_req_addr (ifu2mem_req_addr),
    .mem2ifu_rsp_vld  (mem2ifu_rsp_vld),
    .mem2ifu_rsp_data (mem2ifu_rsp_data),
    .ifu2exu_req_vld  (ifu2exu_req_vld),
    .ifu2exu_req_rdy  (ifu2exu_req_rdy),
    .ifu2exu_req_ir   (ifu2exu_req_ir),
    .ifu2exu_req_pc   (ifu2exu_req_pc),
    .exu2ifu_taken    (exu2ifu_taken),
    .exu2ifu_offset   (exu2ifu_offset)
  );

  typedef struct {
    bit          rst;
    bit          mrdy;
    bit          rvld;
    logic [31:0] rdata;
    bit          erdy;
    bit          tk;
    logic [31:0] off;
    bit          e_mvld;
    logic [31:0] e_addr;
    bit          e_evld;
    logic [31:0] e_epc;
    logic [31:0] e_eir;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic void add(input bit rst, input bit mrdy, input bit rvld,
                              input logic [31:0] rdata, input bit erdy,
                              input bit tk, input logic [31:0] off,
                              input bit mvld, input logic [31:0] addr,
                              input bit evld, input logic [31:0] epc,
                              input logic [31:0] eir);
    vec_t v;
    v.rst = rst; v.mrdy = mrdy; v.rvld = rvld; v.rdata = rdata;
    v.erdy = erdy; v.tk = tk; v.off = off;
    v.e_mvld = mvld; v.e_addr = addr; v.e_evld = evld;
    v.e_epc = epc; v.e_eir = eir;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input bit mvld, input logic [31:0] addr,
                       input bit evld, input logic [31:0] epc,
                       input logic [31:0] eir);
    checks++;
    if (ifu2mem_req_vld !== mvld) begin
      errors++;
      $display("FAIL %s mem_vld got %0b want %0b", nm, ifu2mem_req_vld, mvld);
    end
    checks++;
    if (ifu2mem_req_addr !== addr) begin
      errors++;
      $display("FAIL %s mem_addr got %h want %h", nm, ifu2mem_req_addr, addr);
    end
    checks++;
    if (ifu2exu_req_vld !== evld) begin
      errors++;
      $display("FAIL %s exu_vld got %0b want %0b", nm, ifu2exu_req_vld, evld);
    end
    if (evld) begin
      checks++;
      if (ifu2exu_req_pc !== epc) begin
        errors++;
        $display("FAIL %s exu_pc got %h want %h", nm, ifu2exu_req_pc, epc);
      end
      checks++;
      if (ifu2exu_req_ir !== eir) begin
        errors++;
        $display("FAIL %s exu_ir got %h want %h", nm, ifu2exu_req_ir, eir);
      end
    end
  endtask

  task automatic check_zero(input string nm);
    check(nm, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (ifu2exu_req_pc !== 32'h0 || ifu2exu_req_ir !== 32'h0) begin
      errors++;
      $display("FAIL %s exu_pc/ir got %h/%h want 0/0", nm, ifu2exu_req_pc,
               ifu2exu_req_ir);
    end
  endtask

  task automatic drive(input bit mrdy, input bit rvld, input logic [31:0] rdata,
                       input bit erdy, input bit tk, input logic [31:0] off);
    ifu2mem_req_rdy  = mrdy;
    mem2ifu_rsp_vld  = rvld;
    mem2ifu_rsp_data = rdata;
    ifu2exu_req_rdy  = erdy;
    exu2ifu_taken    = tk;
    exu2ifu_offset   = off;
  endtask

  // Holds reset with junk responses on the bus, checks reset values, then
  // releases on a falling edge so the caller sits in the IDLE cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h40);
    repeat (3) @(negedge clk);
    check_zero("reset");
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic streaming: addrs 0,4,8 / EXU pcs 0,4,8, first EXU vld at c3.
    // Taken asserted in c2 without an EXU transfer must be ignored.
    add(1, 1,0,0,1,0,0,             0,32'h0,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h0,0,0,0);
    add(0, 1,1,dat(0),1,1,32'h40,   0,32'h4,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h4,1,32'h0,dat(0));
    add(0, 1,1,dat(4),1,0,0,        0,32'h8,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h8,1,32'h4,dat(4));
    add(0, 1,1,dat(8),1,0,0,        0,32'hC,0,0,0);
    add(0, 0,0,0,1,0,0,             1,32'hC,1,32'h8,dat(8));
    add(0, 0,0,0,1,0,0,             1,32'hC,0,0,0);

    // EXU stalled: buffer fills, STALL, then drain 0,4 and resume at 8.
    add(1, 1,0,0,0,0,0,             0,32'h0,0,0,0);
    add(0, 1,0,0,0,0,0,             1,32'h0,0,0,0);
    add(0, 1,1,dat(0),0,0,0,        0,32'h4,0,0,0);
    add(0, 1,0,0,0,0,0,             1,32'h4,1,32'h0,dat(0));
    add(0, 1,1,dat(4),0,1,32'h100,  0,32'h8,1,32'h0,dat(0));
    add(0, 1,0,0,0,1,32'h100,       0,32'h8,1,32'h0,dat(0));
    add(0, 1,0,0,1,0,0,             0,32'h8,1,32'h0,dat(0));
    add(0, 0,0,0,1,0,0,             1,32'h8,1,32'h4,dat(4));
    add(0, 1,0,0,1,0,0,             1,32'h8,0,0,0);
    add(0, 1,1,dat(8),1,0,0,        0,32'hC,0,0,0);
    add(0, 0,0,0,1,0,0,             1,32'hC,1,32'h8,dat(8));

    // Redirect from pc 8 (+0x10) while the 0xC fetch is outstanding.
    add(1, 1,0,0,1,0,0,             0,32'h0,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h0,0,0,0);
    add(0, 1,1,dat(0),1,0,0,        0,32'h4,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h4,1,32'h0,dat(0));
    add(0, 1,1,dat(4),1,0,0,        0,32'h8,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h8,1,32'h4,dat(4));
    add(0, 1,1,dat(8),1,0,0,        0,32'hC,0,0,0);
    add(0, 1,0,0,0,0,0,             1,32'hC,1,32'h8,dat(8));
    add(0, 1,0,0,1,1,32'h10,        0,32'h10,1,32'h8,dat(8));
    add(0, 1,1,dat(32'hC),1,0,0,    0,32'h18,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h18,0,0,0);
    add(0, 1,1,dat(32'h18),1,0,0,   0,32'h1C,0,0,0);
    add(0, 0,0,0,1,0,0,             1,32'h1C,1,32'h18,dat(32'h18));

    // Redirect (+0x20) in the same cycle as the 0xC response.
    add(1, 1,0,0,1,0,0,             0,32'h0,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h0,0,0,0);
    add(0, 1,1,dat(0),1,0,0,        0,32'h4,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h4,1,32'h0,dat(0));
    add(0, 1,1,dat(4),1,0,0,        0,32'h8,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h8,1,32'h4,dat(4));
    add(0, 1,1,dat(8),1,0,0,        0,32'hC,0,0,0);
    add(0, 1,0,0,0,0,0,             1,32'hC,1,32'h8,dat(8));
    add(0, 1,1,dat(32'hC),1,1,32'h20, 0,32'h10,1,32'h8,dat(8));
    add(0, 1,0,0,1,0,0,             1,32'h28,0,0,0);
    add(0, 1,1,dat(32'h28),1,0,0,   0,32'h2C,0,0,0);
    add(0, 0,0,0,1,0,0,             1,32'h2C,1,32'h28,dat(32'h28));

    // Redirects while a request is held (address must not move), reaching
    // pc 0xFFFFFFF8 and then wrapping to 0x8.
    add(1, 1,0,0,1,0,0,             0,32'h0,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'h0,0,0,0);
    add(0, 1,1,dat(0),1,0,0,        0,32'h4,0,0,0);
    add(0, 0,0,0,1,1,32'hFFFFFFF8,  1,32'h4,1,32'h0,dat(0));
    add(0, 1,0,0,1,0,0,             1,32'h4,0,0,0);
    add(0, 1,1,dat(4),1,0,0,        0,32'hFFFFFFF8,0,0,0);
    add(0, 1,0,0,1,0,0,             1,32'hFFFFFFF8,0,0,0);
    add(0, 1,1,32'h1234_5678,1,0,0, 0,32'hFFFFFFFC,0,0,0);
    add(0, 0,0,0,1,1,32'h10,        1,32'hFFFFFFFC,1,32'hFFFFFFF8,32'h1234_5678);
    add(0, 1,0,0,1,0,0,             1,32'hFFFFFFFC,0,0,0);
    add(0, 1,1,dat(32'hFFFFFFFC),1,0,0, 0,32'h8,0,0,0);
    add(0, 0,0,0,1,0,0,             1,32'h8,0,0,0);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      check($sformatf("vec%0d", i), vecs[i].e_mvld, vecs[i].e_addr,
            vecs[i].e_evld, vecs[i].e_epc, vecs[i].e_eir);
      drive(vecs[i].mrdy, vecs[i].rvld, vecs[i].rdata, vecs[i].erdy,
            vecs[i].tk, vecs[i].off);
      @(negedge clk);
    end

    // Memory not ready for 5 cycles with addr 0x4 pending.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("hold_c1", 1, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("hold_c2", 0, 32'h4, 0, 0, 0);
    drive(1, 1, dat(0), 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_%0d", k), 1, 32'h4, 1, 32'h0, dat(0));
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    check("hold_end", 1, 32'h4, 1, 32'h0, dat(0));
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("hold_adv", 0, 32'h8, 1, 32'h0, dat(0));

    // Asynchronous reset while a request is outstanding.
    do_reset();
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("arst_wait", 0, 32'h4, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("arst_now");
    drive(0, 1, 32'hBAD0_0000, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    check("arst_idle", 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("arst_req", 1, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, dat(0), 1, 0, 0);
    @(negedge clk);
    check("arst_first", 1, 32'h4, 1, 32'h0, dat(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
